// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Multiplexed common-anode 7-segment scan controller with
//            double-buffered frame-synchronous loading, per-digit decimal
//            points, leading-zero blanking, an anti-ghost blank interval and
//            PWM brightness control.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 96320,
    parameter int BLANK_CYC  = 64,
    parameter int BRIGHT_W   = 4,
    parameter int LZ_BLANK   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic                    pending,
    output logic                    frame_done,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [DIG_W-1:0]  C_DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [TICK_W-1:0] C_BLANK     = TICK_W'(BLANK_CYC);
    localparam logic [6:0]        C_SEG_OFF   = 7'h7F;

    // Scan position
    logic [TICK_W-1:0]       r_tick;
    logic [DIG_W-1:0]        r_dig;

    // Double buffer
    logic [4*NUM_DIGITS-1:0] r_pend_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_active_data;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic                    r_pending;
    logic                    r_frame_done;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    // Combinational helpers
    logic                    w_tick_wrap;
    logic                    w_frame_end;
    logic                    w_past_guard;
    logic                    w_duty;
    logic [NUM_DIGITS-1:0]   w_nz_tail;
    logic                    w_acc;
    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_tick_wrap = (r_tick == C_TICK_LAST);
    assign w_frame_end = w_tick_wrap && (r_dig == C_DIG_LAST);

    // Slot tick and digit index; both wrap back to zero without a gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick <= '0;
            r_dig  <= '0;
        end else if (w_tick_wrap) begin
            r_tick <= '0;
            r_dig  <= (r_dig == C_DIG_LAST) ? '0 : r_dig + 1'b1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    // Pending/active buffers: loads land in pending, the frame end promotes
    // them so the visible value never changes mid-frame. A load on the
    // frame-end cycle bypasses the pending buffer and commits directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_data   <= '0;
            r_pend_dp     <= '0;
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
            end
            if (w_frame_end) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_active_data <= data_in;
                    r_active_dp   <= dp_in;
                end else if (r_pending) begin
                    r_active_data <= r_pend_data;
                    r_active_dp   <= r_pend_dp;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
            r_frame_done <= w_frame_end;
        end
    end

    // Anti-ghost guard: a zero-length guard needs no comparator at all
    generate
        if (BLANK_CYC == 0) begin : g_no_guard
            assign w_past_guard = 1'b1;
        end else begin : g_guard
            assign w_past_guard = (r_tick >= C_BLANK);
        end
    endgenerate

    assign w_duty = (r_tick[BRIGHT_W-1:0] < bright);

    // w_nz_tail[k] is set when any active nibble from k upwards is non-zero
    always_comb begin
        w_nz_tail = '0;
        w_acc     = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_acc        = w_acc | (|r_active_data[4*k +: 4]);
            w_nz_tail[k] = w_acc;
        end
    end

    assign w_nibble = r_active_data[{r_dig, 2'b00} +: 4];
    assign w_blank  = (LZ_BLANK != 0) && (r_dig != '0) && !w_nz_tail[r_dig];

    // Next pin values for the current scan position
    always_comb begin
        w_an_next = '1;
        if (w_past_guard && w_duty) begin
            w_an_next[r_dig] = 1'b0;
        end
        w_seg_next = w_blank ? C_SEG_OFF : hex7(w_nibble);
    end

    // Register an/seg/dp together so the pins switch on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= '1;
            r_seg <= C_SEG_OFF;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= ~r_active_dp[r_dig];
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Scoreboard bench for seg7_scan_ctrl. Stimulus queues the frame
//            it expects to see; a monitor captures whole frames after each
//            frame_done and compares every slot against the queued entry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int ND   = 8;
    localparam int DIV  = 16;
    localparam int BLK  = 2;
    localparam int FLEN = ND * DIV;

    // Active-low glyphs {g,f,e,d,c,b,a}
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GX = 7'h7F;

    typedef struct {
        int               frame;
        logic [7:0][6:0]  segs;
        logic [7:0]       dpl;
        logic [3:0]       br;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic [3:0]  bright;
    logic        pending;
    logic        frame_done;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks;
    int errors;
    int fcount;

    exp_t sb[$];
    exp_t cur;
    logic [6:0] cap_seg [FLEN];
    logic       cap_dp  [FLEN];
    logic [7:0] cap_an  [FLEN];
    bit         cap_on;
    int         cap_idx;

    seg7_scan_ctrl #(
        .NUM_DIGITS (ND),
        .CLK_DIV    (DIV),
        .BLANK_CYC  (BLK),
        .BRIGHT_W   (4),
        .LZ_BLANK   (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .bright     (bright),
        .pending    (pending),
        .frame_done (frame_done),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Compare a captured frame against the popped expectation, per digit
    task automatic check_frame();
        logic       bad_s, bad_d, bad_a;
        logic [7:0] ea;
        logic       ed;
        int         i, ts, td, ta;
        for (int d = 0; d < ND; d++) begin
            bad_s = 1'b0; bad_d = 1'b0; bad_a = 1'b0;
            ts = 0; td = 0; ta = 0;
            ed = ~cur.dpl[d];
            for (int t = 0; t < DIV; t++) begin
                i  = d * DIV + t;
                ea = ((t >= BLK) && (t < int'(cur.br))) ? ~(8'd1 << d) : 8'hFF;
                if (cap_seg[i] !== cur.segs[d] && !bad_s) begin bad_s = 1'b1; ts = t; end
                if (cap_dp[i]  !== ed          && !bad_d) begin bad_d = 1'b1; td = t; end
                if (cap_an[i]  !== ea          && !bad_a) begin bad_a = 1'b1; ta = t; end
            end
            checks += 3;
            if (bad_s) begin
                errors++;
                $display("FAIL frame%0d seg digit%0d tick%0d: got %b want %b",
                         cur.frame, d, ts, cap_seg[d*DIV+ts], cur.segs[d]);
            end
            if (bad_d) begin
                errors++;
                $display("FAIL frame%0d dp digit%0d tick%0d: got %b want %b",
                         cur.frame, d, td, cap_dp[d*DIV+td], ed);
            end
            if (bad_a) begin
                errors++;
                ea = ((ta >= BLK) && (ta < int'(cur.br))) ? ~(8'd1 << d) : 8'hFF;
                $display("FAIL frame%0d an digit%0d tick%0d: got %h want %h",
                         cur.frame, d, ta, cap_an[d*DIV+ta], ea);
            end
        end
    endtask

    // Monitor: on each frame_done, pop a matching expectation and capture
    initial begin
        cap_on  = 1'b0;
        cap_idx = 0;
        fcount  = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                cap_on = 1'b0;
            end else begin
                if (cap_on) begin
                    cap_seg[cap_idx] = seg;
                    cap_dp[cap_idx]  = dp;
                    cap_an[cap_idx]  = an;
                    cap_idx++;
                    if (cap_idx == FLEN) begin
                        check_frame();
                        cap_on = 1'b0;
                    end
                end
                if (frame_done === 1'b1) begin
                    fcount++;
                    if (sb.size() > 0 && sb[0].frame == fcount) begin
                        cur     = sb.pop_front();
                        cap_on  = 1'b1;
                        cap_idx = 0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (frame_done !== 1'b1 && n < 300);
        if (frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: got 0 want 1 within 300 cycles");
        end
    endtask

    task automatic push(input logic [7:0][6:0] s, input logic [7:0] dpl, input logic [3:0] br);
        exp_t e;
        e.frame = fcount + 1;
        e.segs  = s;
        e.dpl   = dpl;
        e.br    = br;
        sb.push_back(e);
    endtask

    task automatic pulse_load(input logic [31:0] v, input logic [7:0] p);
        data_in = v;
        dp_in   = p;
        load    = 1'b1;
        step(1);
        load    = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        data_in = '0;
        dp_in   = '0;
        load    = 1'b0;
        bright  = 4'd15;
        #1 reset = 1'b0;
        step(3);

        // Reset state
        chk("reset_an", 32'(an), 32'hFF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_pending", 32'(pending), 32'h0);
        chk("reset_frame_done", 32'(frame_done), 32'h0);

        // Test 1: first frame after release, load 0x12345678 at cycle 0
        reset = 1'b1;
        push({G1, G2, G3, G4, G5, G6, G7, G8}, 8'h00, 4'd15);
        pulse_load(32'h1234_5678, 8'h00);
        chk("t1_pending_set", 32'(pending), 32'h1);
        step(126);
        chk("t1_fd_before_128", 32'(frame_done), 32'h0);
        step(1);
        chk("t1_fd_at_128", 32'(frame_done), 32'h1);
        chk("t1_pending_clear", 32'(pending), 32'h0);
        step(1);
        chk("t1_fd_one_cycle", 32'(frame_done), 32'h0);

        // Test 2: leading-zero blanking; then all-zero with dp on blank digit 7
        push({GX, GX, GX, GX, GX, GX, GA, G0}, 8'h00, 4'd15);
        pulse_load(32'h0000_00A0, 8'h00);
        wait_fd();
        push({GX, GX, GX, GX, GX, GX, GX, G0}, 8'h80, 4'd15);
        pulse_load(32'h0000_0000, 8'h80);
        wait_fd();

        // Test 3: loads at cycle 40, last one wins, display holds till frame end
        step(40);
        pulse_load(32'h2222_2222, 8'h00);
        push({G1, G1, G1, G1, G1, G1, G1, G1}, 8'h00, 4'd15);
        pulse_load(32'h1111_1111, 8'h00);
        chk("t3_pending_set", 32'(pending), 32'h1);
        wait_fd();
        chk("t3_pending_clear", 32'(pending), 32'h0);

        // Test 4: bright=0 keeps anodes off; bright=4 lights ticks 2,3 only
        push({G1, G1, G1, G1, G1, G1, G1, G1}, 8'h00, 4'd0);
        wait_fd();
        bright = 4'd0;
        push({G1, G1, G1, G1, G1, G1, G1, G1}, 8'h00, 4'd4);
        wait_fd();
        bright = 4'd4;

        // Test 5: load on the exact frame-end cycle
        push({GF, GE, GD, GC, GB, GA, G9, G0}, 8'h05, 4'd15);
        step(127);
        chk("t5_pending_before", 32'(pending), 32'h0);
        pulse_load(32'hFEDC_BA90, 8'h05);
        chk("t5_fd_on_commit", 32'(frame_done), 32'h1);
        chk("t5_pending_stays0", 32'(pending), 32'h0);
        bright = 4'd15;

        // Test 6: asynchronous reset mid-slot
        wait_fd();
        step(37);
        chk("t6_an_before_reset", 32'(an), 32'hFB);
        #2 reset = 1'b0;
        #1;
        chk("t6_an_async", 32'(an), 32'hFF);
        chk("t6_seg_async", 32'(seg), 32'h7F);
        chk("t6_dp_async", 32'(dp), 32'h1);
        chk("t6_pending_async", 32'(pending), 32'h0);
        step(2);
        reset = 1'b1;
        push({GX, GX, GX, GX, GX, GX, GX, G0}, 8'h00, 4'd15);
        step(127);
        chk("t6_fd_before_128", 32'(frame_done), 32'h0);
        step(1);
        chk("t6_fd_at_128", 32'(frame_done), 32'h1);
        wait_fd();

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
